// File: rtl/dsp_mult_arbiter_if.sv
// Requester-side bus of dsp_mult_arbiter: two operand requesters sharing one
// response channel. master = requester side, slave = arbiter side.
interface dsp_mult_arbiter_if;
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [19:0] req0_a_i;
  logic [17:0] req0_b_i;
  logic        req0_unsigned_a_i;
  logic        req0_unsigned_b_i;

  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [19:0] req1_a_i;
  logic [17:0] req1_b_i;
  logic        req1_unsigned_a_i;
  logic        req1_unsigned_b_i;

  logic [1:0]  rsp_valid_o;
  logic [37:0] rsp_z_o;
  logic        busy_o;

  modport master (
    output req0_valid_i, req0_a_i, req0_b_i, req0_unsigned_a_i, req0_unsigned_b_i,
    output req1_valid_i, req1_a_i, req1_b_i, req1_unsigned_a_i, req1_unsigned_b_i,
    input  req0_ready_o, req1_ready_o, rsp_valid_o, rsp_z_o, busy_o
  );

  modport slave (
    input  req0_valid_i, req0_a_i, req0_b_i, req0_unsigned_a_i, req0_unsigned_b_i,
    input  req1_valid_i, req1_a_i, req1_b_i, req1_unsigned_a_i, req1_unsigned_b_i,
    output req0_ready_o, req1_ready_o, rsp_valid_o, rsp_z_o, busy_o
  );
endinterface

// File: rtl/dsp_mult_arbiter.sv
// dsp_mult_arbiter: shares one pipelined DSP multiplier between two requesters.
// A LATENCY-deep tag pipeline tracks which requester owns each product in
// flight; responses come back in issue order with no backpressure.
// Optional feature: define DSP_ARB_ROUND_ROBIN_EN for alternating priority;
// otherwise requester 0 always has priority.
module dsp_mult_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  dsp_mult_arbiter_if.slave   bus,
  output logic [19:0]         dsp_a_o,
  output logic [17:0]         dsp_b_o,
  output logic                dsp_unsigned_a_o,
  output logic                dsp_unsigned_b_o,
  output logic [2:0]          dsp_feedback_o,
  output logic [2:0]          dsp_output_select_o,
  output logic                dsp_register_inputs_o,
  input  logic [37:0]         dsp_z_i
);

  logic               prio;
  logic               grant0;
  logic               grant1;
  logic               issue;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;

  assign dsp_feedback_o        = '0;
  assign dsp_output_select_o   = '0;
  assign dsp_register_inputs_o = 1'b1;

  // Grant: the pointed-to requester wins a tie; nothing is granted in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset_i) begin
      if (!prio) begin
        grant0 = bus.req0_valid_i;
        grant1 = bus.req1_valid_i & ~bus.req0_valid_i;
      end else begin
        grant1 = bus.req1_valid_i;
        grant0 = bus.req0_valid_i & ~bus.req1_valid_i;
      end
    end
  end

  assign issue            = grant0 | grant1;
  assign bus.req0_ready_o = grant0;
  assign bus.req1_ready_o = grant1;

  // DSP operand mux: granted requester's operands, zero when idle.
  always_comb begin
    dsp_a_o          = '0;
    dsp_b_o          = '0;
    dsp_unsigned_a_o = 1'b0;
    dsp_unsigned_b_o = 1'b0;
    if (grant0) begin
      dsp_a_o          = bus.req0_a_i;
      dsp_b_o          = bus.req0_b_i;
      dsp_unsigned_a_o = bus.req0_unsigned_a_i;
      dsp_unsigned_b_o = bus.req0_unsigned_b_i;
    end else if (grant1) begin
      dsp_a_o          = bus.req1_a_i;
      dsp_b_o          = bus.req1_b_i;
      dsp_unsigned_a_o = bus.req1_unsigned_a_i;
      dsp_unsigned_b_o = bus.req1_unsigned_b_i;
    end
  end

  // Tag pipeline: shifts every cycle, mirroring the DSP's own latency.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= issue;
      tag_id[0]    <= grant1;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Priority pointer: alternates after each issue, or stays on requester 0.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      prio <= 1'b0;
    end else begin
`ifdef DSP_ARB_ROUND_ROBIN_EN
      if (issue) prio <= grant0;
`else
      prio <= 1'b0;
`endif
    end
  end

  // Response decode: the exiting tag steers the DSP product to its owner.
  always_comb begin
    bus.rsp_valid_o = '0;
    bus.rsp_z_o     = '0;
    if (tag_valid[LATENCY-1]) begin
      bus.rsp_valid_o[tag_id[LATENCY-1]] = 1'b1;
      bus.rsp_z_o                        = dsp_z_i;
    end
  end

  assign bus.busy_o = |tag_valid;

endmodule

// File: doc/dsp_mult_arbiter.md
DSP_MULT_ARBITER -- requirements
Module: dsp_mult_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1, cycles from issue to valid dsp_z_i; legal range 1..4.
REQ-002 clock_i  input  1  single clock; all state on rising edge.
REQ-003 reset_i  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid_i (N=0,1)  input  1  requester N has an operand pair.
REQ-005 reqN_ready_o  output  1  requester N is granted this cycle.
REQ-006 reqN_a_i  input  20  multiplicand A.
REQ-007 reqN_b_i  input  18  multiplicand B.
REQ-008 reqN_unsigned_a_i / reqN_unsigned_b_i  input  1 each  operand signedness.
REQ-009 rsp_valid_o  output  2  one-hot product-valid, bit N for requester N.
REQ-010 rsp_z_o  output  38  product, shared by both requesters.
REQ-011 dsp_a_o, dsp_b_o  output  20, 18  operands to the shared DSP.
REQ-012 dsp_unsigned_a_o, dsp_unsigned_b_o  output  1 each  signedness to the DSP.
REQ-013 dsp_feedback_o, dsp_output_select_o  output  3 each  constant 3'h0.
REQ-014 dsp_register_inputs_o  output  1  constant 1'b1.
REQ-015 dsp_z_i  input  38  DSP product.
REQ-016 busy_o  output  1  at least one operation is in flight.

Function
REQ-017 Grant logic SHALL be combinational from the valid inputs and the priority pointer; at most one ready_o is high per cycle.
REQ-018 Issue SHALL occur when valid_i and ready_o are both high; no ready_o SHALL be asserted while no valid_i is high.
REQ-019 On issue, dsp_a_o, dsp_b_o and the signedness outputs SHALL carry the granted requester's inputs in the same cycle; otherwise they SHALL be zero.
REQ-020 A LATENCY-deep tag shift register (valid and requester id) SHALL advance every cycle; one issue per cycle gives full throughput.
REQ-021 When a tag exits, the controller SHALL assert rsp_valid_o[id] for exactly one cycle, with rsp_z_o = dsp_z_i; otherwise rsp_valid_o SHALL be 2'b00 and rsp_z_o SHALL be 0.
REQ-022 Responses SHALL return in issue order, with no backpressure; requesters SHALL accept them.
REQ-023 busy_o SHALL equal the OR of all tag valid bits.
REQ-024 A 1-bit priority pointer SHALL select the highest-priority requester: 0 selects req0, 1 selects req1.

Reset
REQ-025 Asserting reset_i SHALL immediately clear all tags and set the pointer to 0; rsp_valid_o=0, rsp_z_o=0, busy_o=0 and ready_o=0 while reset_i is high.
REQ-026 Operations in flight at reset SHALL be dropped; no rsp_valid_o SHALL be asserted for them after reset is released.
REQ-027 The first rising edge after deassertion SHALL be able to issue.

Configuration
REQ-028 With DSP_ARB_ROUND_ROBIN_EN defined, after an issue to requester k the pointer SHALL move to the other requester, so two continuously valid requesters alternate.
REQ-029 Without DSP_ARB_ROUND_ROBIN_EN, the pointer SHALL stay at 0 (fixed priority: req0 always wins).

Verification
REQ-030 LATENCY=1, req0 only, A=-3, B=7, signed: rsp_valid_o=2'b01 one cycle after issue, rsp_z_o=-21.
REQ-031 Both requesters valid for 4 cycles, round-robin enabled: grant order 0,1,0,1; responses 01,10,01,10 in consecutive cycles.
REQ-032 Same stimulus, macro undefined: req1_ready_o stays 0; four 2'b01 responses.
REQ-033 req1 unsigned A=20'hFFFFF, B=18'd2, unsigned_b=1: rsp_z_o=38'h1FFFFE.
REQ-034 LATENCY=3, issue, then assert reset_i 1 cycle later: busy_o drops at once; no rsp_valid_o for 5 cycles after release.
REQ-035 Random signed operands back-to-back for 100 cycles: every rsp_z_o matches the A*B reference in order; busy_o=0 once traffic stops and LATENCY cycles have passed.
